// File: rtl/mult_pkg.sv
// Shared types and defaults for the EX-stage multiplier (ex_mult4_unit).
package mult_pkg;

  typedef enum logic [1:0] {
    MUL_LO  = 2'b00,
    MUL_HSS = 2'b01,
    MUL_HSU = 2'b10,
    MUL_HUU = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int MULT_LATENCY = 4;

endpackage

// File: rtl/mult_pipe_array.sv
// Pipelined OPW x OPW multiplier: one partial-sum stage per chunk of b, product
// modulo 2^(2*OPW), so sign-extended operands give the exact two's-complement product.
module mult_pipe_array
  import mult_pkg::*;
#(
  parameter int OPW      = 33,
  parameter int STAGES   = MULT_LATENCY - 1,
  parameter bit SIGN_EXT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kill,
  input  logic             vld_in,
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  output logic [2*OPW-1:0] product,
  output logic             vld_out
);

  localparam int PW  = 2 * OPW;
  localparam int CW  = (PW + STAGES - 1) / STAGES;
  localparam int BPW = CW * STAGES;

  function automatic logic [PW-1:0] widen(input logic [OPW-1:0] x);
    widen = SIGN_EXT ? {{OPW{x[OPW-1]}}, x} : {{OPW{1'b0}}, x};
  endfunction

  function automatic logic [PW-1:0] partial(input logic [PW-1:0] m, input logic [CW-1:0] c);
    logic [PW-1:0] cx;
    cx = '0;
    cx[CW-1:0] = c;
    partial = m * cx;
  endfunction

  logic [PW-1:0]     a_p   [STAGES];
  logic [BPW-1:0]    b_p   [STAGES];
  logic [PW-1:0]     acc_p [STAGES];
  logic [STAGES-1:0] vld_p;
  logic [PW-1:0]     a_in;
  logic [BPW-1:0]    b_in;

  assign a_in = widen(a);
  assign b_in = BPW'(widen(b));

  // Stage 0: lowest chunk of b; b is kept pre-shifted so each stage reads bits [CW-1:0]
  always_ff @(posedge clk) begin
    a_p[0]   <= a_in;
    b_p[0]   <= b_in >> CW;
    acc_p[0] <= partial(a_in, b_in[CW-1:0]);
    if (rst || kill) vld_p[0] <= 1'b0;
    else             vld_p[0] <= vld_in;
  end

  for (genvar k = 1; k < STAGES; k++) begin : g_stage
    // Stage k: accumulate chunk k at weight 2^(k*CW)
    always_ff @(posedge clk) begin
      a_p[k]   <= a_p[k-1];
      b_p[k]   <= b_p[k-1] >> CW;
      acc_p[k] <= acc_p[k-1] + (partial(a_p[k-1], b_p[k-1][CW-1:0]) << (k * CW));
      if (rst || kill) vld_p[k] <= 1'b0;
      else             vld_p[k] <= vld_p[k-1];
    end
  end

  assign product = acc_p[STAGES-1];
  assign vld_out = vld_p[STAGES-1];

endmodule

// File: rtl/ex_mult4_unit.sv
// EX-stage fixed-latency multiplier with hazard-unit stall request.
// Define MULT_HIGH_EN to support MULH/MULHSU/MULHU; otherwise only MUL (low word).
module ex_mult4_unit
  import mult_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LATENCY = MULT_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              flush,
  input  logic [1:0]        mul_op,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              stall_req,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  state_t     state;
  logic [CNT_W-1:0] cnt;
  logic       accept;

  assign accept = (state == IDLE) && start && !flush;

`ifdef MULT_HIGH_EN
  localparam int OPW      = DATA_W + 1;
  localparam bit SIGN_EXT = 1'b1;

  mul_op_t        op_in;
  mul_op_t        op_q;
  logic           a_sgn;
  logic           b_sgn;
  logic [OPW-1:0] a_x;
  logic [OPW-1:0] b_x;

  assign op_in = mul_op_t'(mul_op);
  assign a_sgn = (op_in == MUL_HSS) || (op_in == MUL_HSU);
  assign b_sgn = (op_in == MUL_HSS);
  assign a_x   = {a_sgn & op_a[DATA_W-1], op_a};
  assign b_x   = {b_sgn & op_b[DATA_W-1], op_b};
`else
  localparam int OPW      = DATA_W;
  localparam bit SIGN_EXT = 1'b0;

  logic [OPW-1:0] a_x;
  logic [OPW-1:0] b_x;
  logic           unused_op;

  assign a_x       = op_a;
  assign b_x       = op_b;
  assign unused_op = ^mul_op;
`endif

  logic [2*OPW-1:0]  product;
  logic              prod_vld;
  logic [DATA_W-1:0] res_sel;
  logic              unused_top;

  mult_pipe_array #(
    .OPW      (OPW),
    .STAGES   (LATENCY - 1),
    .SIGN_EXT (SIGN_EXT)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .kill    (flush),
    .vld_in  (accept),
    .a       (a_x),
    .b       (b_x),
    .product (product),
    .vld_out (prod_vld)
  );

`ifdef MULT_HIGH_EN
  assign res_sel    = (op_q == MUL_LO) ? product[DATA_W-1:0] : product[2*DATA_W-1:DATA_W];
  assign unused_top = ^product[2*OPW-1:2*DATA_W];
`else
  assign res_sel    = product[DATA_W-1:0];
  assign unused_top = ^product[2*OPW-1:DATA_W];
`endif

  // Sequencer: the array is free-running, the FSM only counts stages and gates done
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      stall_req <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
`ifdef MULT_HIGH_EN
            op_q      <= op_in;
`endif
            cnt       <= CNT_W'(LATENCY - 1);
            state     <= RUN;
            busy      <= 1'b1;
            stall_req <= 1'b1;
          end
        end
        RUN: begin
          if (flush) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            stall_req <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state     <= DONE;
              stall_req <= 1'b0;
              done      <= prod_vld;
              if (prod_vld) result <= res_sel;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          stall_req <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  a_start_while_busy: assert property (@(posedge clk) disable iff (rst) !(start && busy))
    else $warning("ex_mult4_unit: start ignored while busy");
`endif

endmodule

// File: tb/tb_ex_mult4_unit.sv
// Scoreboard bench for ex_mult4_unit; covers both MULT_HIGH_EN builds.
module tb_ex_mult4_unit;

  localparam int DATA_W  = 32;
  localparam int LATENCY = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              flush;
  logic [1:0]        mul_op;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              busy;
  logic              stall_req;
  logic              done;
  logic [DATA_W-1:0] result;

  int tests = 0;
  int fails = 0;
  int done_seen = 0;
  logic [DATA_W-1:0] exp_q[$];

  ex_mult4_unit #(.DATA_W(DATA_W), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .flush     (flush),
    .mul_op    (mul_op),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .stall_req (stall_req),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  // Reference model, written independently of the chunked array
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_HIGH_EN
    logic signed [32:0] ax;
    logic signed [32:0] bx;
    logic signed [65:0] p;
    ax = (op == 2'b01 || op == 2'b10) ? $signed({a[31], a}) : $signed({1'b0, a});
    bx = (op == 2'b01) ? $signed({b[31], b}) : $signed({1'b0, b});
    p  = ax * bx;
    return (op == 2'b00) ? p[31:0] : p[63:32];
`else
    logic [63:0] p;
    logic [1:0]  unused_op;
    unused_op = op;
    p = {32'd0, a} * {32'd0, b};
    return p[31:0];
`endif
  endfunction

  // Scoreboard: every done pulse must match the oldest expected result
  always @(negedge clk) begin
    if (done) begin
      done_seen++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_done: got result=%h, required no done pulse", result);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (result !== e) begin
          fails++;
          $display("FAIL sb_result: got %h, required %h", result, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start  = s;
    mul_op = op;
    op_a   = a;
    op_b   = b;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    drive(1'b0, 2'b00, '0, '0);
    step(); step();
    tests += 4;
    if (busy !== 1'b0)      begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (stall_req !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b, required 0", stall_req); end
    if (done !== 1'b0)      begin fails++; $display("FAIL reset_done: got %b, required 0", done); end
    if (result !== '0)      begin fails++; $display("FAIL reset_result: got %h, required 0", result); end
    rst = 1'b0;
  endtask

  task automatic test_basic_mul();
    drive(1'b1, 2'b00, 32'd7, 32'd6);
    exp_q.push_back(32'd42);
    step();
    start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tests += 3;
      if (stall_req !== 1'b1) begin fails++; $display("FAIL basic_stall_T%0d: got %b, required 1", c, stall_req); end
      if (busy !== 1'b1)      begin fails++; $display("FAIL basic_busy_T%0d: got %b, required 1", c, busy); end
      if (done !== 1'b0)      begin fails++; $display("FAIL basic_early_done_T%0d: got %b, required 0", c, done); end
      step();
    end
    tests += 4;
    if (done !== 1'b1)      begin fails++; $display("FAIL basic_done_T4: got %b, required 1", done); end
    if (result !== 32'd42)  begin fails++; $display("FAIL basic_result_T4: got %0d, required 42", result); end
    if (stall_req !== 1'b0) begin fails++; $display("FAIL basic_stall_T4: got %b, required 0", stall_req); end
    if (busy !== 1'b1)      begin fails++; $display("FAIL basic_busy_T4: got %b, required 1", busy); end
    step();
    tests += 2;
    if (done !== 1'b0) begin fails++; $display("FAIL basic_done_T5: got %b, required 0", done); end
    if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_T5: got %b, required 0", busy); end
  endtask

  // Issue one op and wait (bounded) for its done pulse
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expv);
    int n;
    drive(1'b1, op, a, b);
    exp_q.push_back(expv);
    step();
    start = 1'b0;
    n = 1;
    while (!done && n < 16) begin
      step();
      n++;
    end
    tests += 2;
    if (!done) begin
      fails++; $display("FAIL %s_timeout: no done after %0d cycles, required %0d", name, n, LATENCY);
    end else if (result !== expv) begin
      fails++; $display("FAIL %s_result: got %h, required %h", name, result, expv);
    end
    if (n !== LATENCY) begin fails++; $display("FAIL %s_latency: got %0d, required %0d", name, n, LATENCY); end
    step();
  endtask

`ifdef MULT_HIGH_EN
  task automatic test_high_ops();
    run_op("mulh_m1",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run_op("mulhu_m1",  2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulhsu_mn", 2'b10, 32'h8000_0000, 32'd2,         32'hFFFF_FFFF);
    run_op("mul_lo_m1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
  endtask
`else
  task automatic test_low_only();
    run_op("low_only_op3", 2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
    run_op("low_only_op1", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
  endtask
`endif

  task automatic test_random();
    logic [31:0] a, b;
    logic [1:0]  op;
    for (int i = 0; i < 8; i++) begin
      a  = (i == 0) ? 32'h8000_0000 : $urandom;
      b  = (i == 0) ? 32'h7FFF_FFFF : $urandom;
      op = 2'($urandom_range(0, 3));
      run_op($sformatf("rand%0d", i), op, a, b, model(op, a, b));
    end
  endtask

  task automatic test_flush();
    int d0;
    d0 = done_seen;
    drive(1'b1, 2'b00, 32'd3, 32'd5);
    step();                         // T1
    start = 1'b0;
    step();                         // T2
    flush = 1'b1;
    step();                         // T3
    flush = 1'b0;
    tests += 2;
    if (busy !== 1'b0)      begin fails++; $display("FAIL flush_busy_T3: got %b, required 0", busy); end
    if (stall_req !== 1'b0) begin fails++; $display("FAIL flush_stall_T3: got %b, required 0", stall_req); end
    drive(1'b1, 2'b00, 32'd11, 32'd13);
    exp_q.push_back(32'd143);
    step();                         // T4
    start = 1'b0;
    for (int c = 4; c <= 6; c++) begin
      tests++;
      if (done !== 1'b0) begin fails++; $display("FAIL flush_done_T%0d: got %b, required 0", c, done); end
      step();
    end
    tests += 2;                     // T7
    if (done !== 1'b1)      begin fails++; $display("FAIL flush_restart_done_T7: got %b, required 1", done); end
    if (result !== 32'd143) begin fails++; $display("FAIL flush_restart_result: got %0d, required 143", result); end
    step();
    tests++;
    if (done_seen !== d0 + 1) begin fails++; $display("FAIL flush_done_count: got %0d, required %0d", done_seen - d0, 1); end
  endtask

  task automatic test_reset_midop();
    int d0;
    d0 = done_seen;
    drive(1'b1, 2'b00, 32'd100, 32'd100);
    step();                         // T1
    start = 1'b0;
    step();                         // T2
    rst = 1'b1;
    step();                         // T3
    rst = 1'b0;
    tests += 4;
    if (busy !== 1'b0)      begin fails++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
    if (stall_req !== 1'b0) begin fails++; $display("FAIL rstmid_stall: got %b, required 0", stall_req); end
    if (done !== 1'b0)      begin fails++; $display("FAIL rstmid_done: got %b, required 0", done); end
    if (result !== '0)      begin fails++; $display("FAIL rstmid_result: got %h, required 0", result); end
    repeat (4) step();
    tests++;
    if (done_seen !== d0) begin fails++; $display("FAIL rstmid_done_count: got %0d, required 0", done_seen - d0); end
  endtask

  task automatic test_collisions();
    int d0;
    d0 = done_seen;
    drive(1'b1, 2'b00, 32'd4, 32'd4);
    flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL coll_start_flush_busy: got %b, required 0", busy); end
    repeat (5) step();
    tests++;
    if (done_seen !== d0) begin fails++; $display("FAIL coll_start_flush_done: got %0d pulses, required 0", done_seen - d0); end

    d0 = done_seen;
    drive(1'b1, 2'b00, 32'd9, 32'd9);
    exp_q.push_back(32'd81);
    step();                         // T1: start again while busy
    drive(1'b1, 2'b00, 32'd100, 32'd3);
    step();                         // T2
    step();                         // T3
    start = 1'b0;
    step();                         // T4
    tests += 2;
    if (done !== 1'b1)     begin fails++; $display("FAIL coll_busy_done_T4: got %b, required 1", done); end
    if (result !== 32'd81) begin fails++; $display("FAIL coll_busy_result: got %0d, required 81", result); end
    repeat (6) step();
    tests++;
    if (done_seen !== d0 + 1) begin fails++; $display("FAIL coll_busy_pulses: got %0d, required 1", done_seen - d0); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2'b00, 32'd12, 32'd12);
    exp_q.push_back(32'd144);
    step();                         // T1
    start = 1'b0;
    repeat (3) step();              // T4
    tests++;
    if (done !== 1'b1) begin fails++; $display("FAIL b2b_first_done_T4: got %b, required 1", done); end
    step();                         // T5
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL b2b_busy_T5: got %b, required 0", busy); end
    drive(1'b1, 2'b00, 32'hFFFF_FFFF, 32'd2);
    exp_q.push_back(model(2'b00, 32'hFFFF_FFFF, 32'd2));
    step();                         // T6
    start = 1'b0;
    repeat (3) step();              // T9
    tests += 2;
    if (done !== 1'b1)            begin fails++; $display("FAIL b2b_second_done_T9: got %b, required 1", done); end
    if (result !== 32'hFFFF_FFFE) begin fails++; $display("FAIL b2b_second_result: got %h, required fffffffe", result); end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic_mul();
`ifdef MULT_HIGH_EN
    test_high_ops();
`else
    test_low_only();
`endif
    test_random();
    test_flush();
    test_reset_midop();
    test_collisions();
    test_back_to_back();
    repeat (3) step();
    tests++;
    if (exp_q.size() !== 0) begin fails++; $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
